// File: rtl/input_cond_pkg.sv
// Shared types and default constants for the two-channel button/switch input conditioner.
// Latency: n/a (types only).
// Backpressure: n/a.
package input_cond_pkg;

    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W_DEFAULT     = 20;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability FSM/counter, optional rise pulse (INPUT_COND_EDGE_EN).
// Latency: clean follows a held raw level DB_CYCLES+1 edges after the edge that first samples it.
// Backpressure: none; free-running, one sample per clock.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
`ifdef INPUT_COND_EDGE_EN
    ,
    output logic rise
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             clean_q, clean_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ;
`ifdef INPUT_COND_EDGE_EN
    logic             rise_q, rise_d;
`endif

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
`ifdef INPUT_COND_EDGE_EN
        rise_d  = 1'b0;
`endif
        differ  = (s2_q != clean_q);

        unique case (state_q)
            IDLE_LO, IDLE_HI: begin
                if (differ) begin
                    state_d = (state_q == IDLE_LO) ? WAIT_HI : WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI, WAIT_LO: begin
                if (!differ) begin
                    // Input fell back before the window closed: drop it silently.
                    state_d = (state_q == WAIT_HI) ? IDLE_LO : IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = (state_q == WAIT_HI) ? IDLE_HI : IDLE_LO;
                    cnt_d   = '0;
                    clean_d = ~clean_q;
`ifdef INPUT_COND_EDGE_EN
                    rise_d  = (state_q == WAIT_HI);
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            clean_q <= 1'b0;
            state_q <= IDLE_LO;
            cnt_q   <= '0;
`ifdef INPUT_COND_EDGE_EN
            rise_q  <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            clean_q <= clean_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef INPUT_COND_EDGE_EN
            rise_q  <= rise_d;
`endif
        end
    end

    assign clean = clean_q;
`ifdef INPUT_COND_EDGE_EN
    assign rise  = rise_q;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounced button/switch channels feeding the downstream OR-gate stage (d, e); rise pulses with INPUT_COND_EDGE_EN.
// Latency: btn_clean changes DB_CYCLES+1 edges after the edge that first samples a held new level.
// Backpressure: none; outputs are registered levels/pulses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_clean
`ifdef INPUT_COND_EDGE_EN
    ,
    output logic [1:0] btn_rise
`endif
);

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw[0]),
        .clean (btn_clean[0])
`ifdef INPUT_COND_EDGE_EN
        ,
        .rise  (btn_rise[0])
`endif
    );

    debounce_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw[1]),
        .clean (btn_clean[1])
`ifdef INPUT_COND_EDGE_EN
        ,
        .rise  (btn_rise[1])
`endif
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DB_CYCLES=4, CNT_W=3; rise checks only in the INPUT_COND_EDGE_EN build.
// Inputs change 1 ns after a rising edge, so the next edge is the sampling edge k; clean is expected at k+5.
module tb_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [1:0] btn_clean;
`ifdef INPUT_COND_EDGE_EN
    logic [1:0] btn_rise;
`endif

    int errors = 0;
    int checks = 0;

    input_conditioner #(
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean)
`ifdef INPUT_COND_EDGE_EN
        ,
        .btn_rise  (btn_rise)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_clean(input string tag, input logic [1:0] exp);
        chk(tag, btn_clean, exp);
    endtask

    task automatic chk_rise(input string tag, input logic [1:0] exp);
`ifdef INPUT_COND_EDGE_EN
        chk(tag, btn_rise, exp);
`else
        if (tag.len() < 0) $display("%s %b", tag, exp);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b00;

        // Reset state
        tick(3);
        chk_clean("reset_clean", 2'b00);
        chk_rise("reset_rise", 2'b00);
        rst_n = 1'b1;
        tick(2);
        chk_clean("idle_clean", 2'b00);

        // Clean press on bit 0: sampled at edge k, clean at k+5
        btn_raw = 2'b01;
        tick(5);
        chk_clean("press_k4", 2'b00);
        tick(1);
        chk_clean("press_k5", 2'b01);
        chk_rise("press_rise", 2'b01);
        tick(1);
        chk_clean("press_hold", 2'b01);
        chk_rise("press_rise_end", 2'b00);

        // Release of bit 0
        btn_raw = 2'b00;
        tick(5);
        chk_clean("release_k4", 2'b01);
        tick(1);
        chk_clean("release_k5", 2'b00);
        chk_rise("release_no_rise", 2'b00);
        tick(2);

        // Glitch: three cycles high is the longest pulse that must be rejected
        btn_raw = 2'b01;
        tick(3);
        btn_raw = 2'b00;
        for (int i = 0; i < 10; i++) begin
            chk_clean("glitch_clean", 2'b00);
            chk_rise("glitch_rise", 2'b00);
            tick(1);
        end

        // Bounce on bit 1: 1,0,1,0 one cycle each, then held 1
        btn_raw = 2'b10; tick(1);
        btn_raw = 2'b00; tick(1);
        btn_raw = 2'b10; tick(1);
        btn_raw = 2'b00; tick(1);
        btn_raw = 2'b10;
        tick(5);
        chk_clean("bounce_k4", 2'b00);
        tick(1);
        chk_clean("bounce_k5", 2'b10);
        chk_rise("bounce_rise", 2'b10);
        tick(1);
        chk_rise("bounce_rise_end", 2'b00);
        btn_raw = 2'b00;
        tick(6);
        chk_clean("bounce_release", 2'b00);
        tick(2);

        // Simultaneous press and release on both channels
        btn_raw = 2'b11;
        tick(5);
        chk_clean("simul_k4", 2'b00);
        tick(1);
        chk_clean("simul_k5", 2'b11);
        chk_rise("simul_rise", 2'b11);
        tick(1);
        chk_rise("simul_rise_end", 2'b00);
        btn_raw = 2'b00;
        tick(5);
        chk_clean("simul_rel_k4", 2'b11);
        chk_rise("simul_rel_rise_k4", 2'b00);
        tick(1);
        chk_clean("simul_rel_k5", 2'b00);
        chk_rise("simul_rel_rise_k5", 2'b00);
        tick(2);

        // Reset while bit 0 is mid-debounce; press held through release
        btn_raw = 2'b01;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk_clean("midwait_rst_clean", 2'b00);
        chk_rise("midwait_rst_rise", 2'b00);
        tick(2);
        chk_clean("midwait_in_rst", 2'b00);
        rst_n = 1'b1;
        tick(5);
        chk_clean("after_rst_k4", 2'b00);
        tick(1);
        chk_clean("after_rst_k5", 2'b01);
        chk_rise("after_rst_rise", 2'b01);
        tick(1);

        // Asynchronous reset with clean high: must clear before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_clean("async_rst_clean", 2'b00);
        btn_raw = 2'b00;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        chk_clean("final_idle", 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 20, debounce counter width.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_raw  input  2  raw asynchronous switch/button levels; bit 0 and bit 1 are independent channels.
REQ-006 SHALL have port btn_clean  output  2  debounced registered levels; bit 0 and bit 1 drive the d and e inputs of the downstream OR-gate stage.
REQ-007 SHALL have port btn_rise  output  2  one-cycle pulse per channel on each 0->1 transition of btn_clean; present only when the Configuration macro is defined.

Function
REQ-008 SHALL pass each btn_raw bit through a two-flop synchronizer (s1, s2) before any other logic.
REQ-009 SHALL implement a per-channel FSM with states IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-010 SHALL, in IDLE_LO/IDLE_HI, move to WAIT_HI/WAIT_LO with counter=1 when s2 differs from btn_clean; otherwise stay, counter=0.
REQ-011 SHALL, in WAIT_x, increment the counter each cycle while s2 differs from btn_clean.
REQ-012 SHALL, in WAIT_x, return to the matching IDLE state with counter=0 on any cycle where s2 equals btn_clean (glitch rejected, no output change).
REQ-013 SHALL, in WAIT_x, when counter==DB_CYCLES-1 and s2 still differs, toggle btn_clean at the next edge, enter the opposite IDLE state, and clear the counter.
REQ-014 SHALL give a latency of exactly: btn_clean changes at edge k+DB_CYCLES+1, where edge k is the first edge that samples the new, then continuously held, level into s1.
REQ-015 SHALL keep channels fully independent; simultaneous transitions on both bits SHALL each follow REQ-010..REQ-014 with no interaction.
REQ-016 SHALL never wrap the counter; the counter SHALL NOT exceed DB_CYCLES-1.
REQ-017 SHALL drive btn_clean directly from a flop (no combinational path from btn_raw).

Reset
REQ-018 SHALL, while rst_n=0, force s1, s2, btn_clean, btn_rise to 2'b00, both FSMs to IDLE_LO, counters to 0, regardless of clk.
REQ-019 SHALL abandon any in-progress debounce on reset mid-WAIT; after release, a held-high input SHALL produce btn_clean=1 per REQ-014, counting from the first edge after release.

Configuration
REQ-020 SHALL, with INPUT_COND_EDGE_EN defined, provide btn_rise: registered, high for exactly the one cycle following the edge at which btn_clean goes 0->1, 2'b00 otherwise.
REQ-021 SHALL, without INPUT_COND_EDGE_EN, omit the btn_rise port and its flops; btn_clean behaviour SHALL be identical.

Structure
REQ-022 SHALL place the FSM state enum (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO) and the default DB_CYCLES/CNT_W constants in package input_cond_pkg.
REQ-023 SHALL implement one channel (synchronizer, FSM, counter, optional edge flop) in sub-module debounce_channel, instantiated twice by input_conditioner.

Verification (DB_CYCLES=4, CNT_W=3)
REQ-024 SHALL check clean press: btn_raw=01 held from edge k -> btn_clean=01 at edge k+5, btn_rise=01 for one cycle after (EDGE_EN build).
REQ-025 SHALL check glitch: btn_raw bit0 high for 3 cycles then low -> btn_clean stays 00, btn_rise never asserts.
REQ-026 SHALL check bounce: bit1 toggled 1,0,1,0 every cycle then held 1 -> btn_clean[1] rises exactly 5 edges after the final 0->1 sampling edge.
REQ-027 SHALL check simultaneous: btn_raw 00->11 on one edge -> both bits of btn_clean rise on the same edge; release 11->00 -> both fall together, no btn_rise.
REQ-028 SHALL check reset mid-WAIT: rst_n=0 two cycles after a press -> outputs 00 immediately; press held through release -> btn_clean=01 five edges after release.
REQ-029 SHALL check non-EDGE build: same stimulus as REQ-024 gives identical btn_clean and elaborates with no btn_rise port.
